test_port_write_sniffer: RTL and testbench

//  Sits between the CPU data-memory write bus and the result checker. Watches stores to the

---
 rtl/sniff_pkg.sv | 20 ++
 rtl/test_port_write_sniffer_if.sv | 27 ++
 rtl/sniff_fifo.sv | 55 +++++
 rtl/test_port_write_sniffer.sv | 92 +++++++++
 tb/tb_test_port_write_sniffer.sv | 200 ++++++++++++++++++++
 5 files changed

// File: rtl/sniff_pkg.sv
// Shared constants for the test-port write sniffer and its result checker.
// Test-port address, Begin/End markers (readable byte order), FSM encoding,
// and the bus-word byte swap used to turn little-endian stores into readable words.
package sniff_pkg;

  localparam logic [29:0] TEST_PORT = 30'h10;
  localparam logic [31:0] BEGIN_SYM = 32'h00000168;
  localparam logic [31:0] END_SYM   = 32'hFFFFFD5D;

  localparam int STAMP_W = 16;

  localparam logic [1:0] ST_IDLE    = 2'b00;
  localparam logic [1:0] ST_CAPTURE = 2'b01;
  localparam logic [1:0] ST_DONE    = 2'b10;

  function automatic logic [31:0] byte_swap(input logic [31:0] w);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

endpackage

// File: rtl/test_port_write_sniffer_if.sv
// Bus bundle for the sniffer: data-memory write bus in, event stream out.
// master = CPU/checker side (drives the store bus and out_ready),
// slave = sniffer side. SNIFF_TIMESTAMP_EN adds out_stamp next to out_data.
interface test_port_write_sniffer_if;
  import sniff_pkg::*;

  logic [29:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_wen;
  logic        out_valid;
  logic [31:0] out_data;
  logic        out_ready;
`ifdef SNIFF_TIMESTAMP_EN
  logic [STAMP_W-1:0] out_stamp;

  modport master (output mem_addr, mem_wdata, mem_wen, out_ready,
                  input  out_valid, out_data, out_stamp);
  modport slave  (input  mem_addr, mem_wdata, mem_wen, out_ready,
                  output out_valid, out_data, out_stamp);
`else
  modport master (output mem_addr, mem_wdata, mem_wen, out_ready,
                  input  out_valid, out_data);
  modport slave  (input  mem_addr, mem_wdata, mem_wen, out_ready,
                  output out_valid, out_data);
`endif

endinterface

// File: rtl/sniff_fifo.sv
// Synchronous FIFO, WIDTH x DEPTH (DEPTH power of two, >=2).
// Latency: push in cycle N is visible at head in N+1; pop is combinational on pop_req.
// Backpressure: push accepted when not full or when a pop frees a slot the same cycle.
// Ports: push/push_data/push_ok (write side), pop_req/valid/head (read side).
module sniff_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  output logic             push_ok,
  input  logic             pop_req,
  output logic             valid,
  output logic [WIDTH-1:0] head
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [WIDTH-1:0] last_q;
  logic             empty;
  logic             full;
  logic             pop;

  // Extra pointer MSB distinguishes full from empty when the index bits match.
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop     = pop_req && !empty;
  assign push_ok = push && (!full || pop);
  assign valid   = !empty;
  // When empty the head keeps showing the last word that left the FIFO.
  assign head    = empty ? last_q : mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      last_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push_ok) begin
        mem[wr_ptr[AW-1:0]] <= push_data;
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        last_q <= mem[rd_ptr[AW-1:0]];
        rd_ptr <= rd_ptr + 1'b1;
      end
    end
  end

endmodule

// File: rtl/test_port_write_sniffer.sv
// Collapses test-port stores into single events, byte-swaps them, frames them Begin..End, queues them.
// Latency: event in cycle N appears on out_valid/out_data at N+1 at earliest.
// Backpressure: out_valid/out_ready stream; an event arriving at a full FIFO is dropped and sets overflow.
// Ports: clk, rst (async active-low), bus (slave: store bus in, event stream out),
// capturing, done, overflow (sticky), event_cnt (saturating). Macro: SNIFF_TIMESTAMP_EN adds out_stamp.
module test_port_write_sniffer
  import sniff_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int CNT_W = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  test_port_write_sniffer_if.slave  bus,
  output logic                      capturing,
  output logic                      done,
  output logic                      overflow,
  output logic [CNT_W-1:0]          event_cnt
);

`ifdef SNIFF_TIMESTAMP_EN
  localparam int FW = 32 + STAMP_W;
`else
  localparam int FW = 32;
`endif

  logic [1:0]    state;
  logic          wen_q;
  logic [31:0]   swapped;
  logic          evt;
  logic          push;
  logic          push_ok;
  logic [FW-1:0] fifo_in;
  logic [FW-1:0] fifo_head;

  assign swapped = byte_swap(bus.mem_wdata);
  // Only the rising edge of a stalled store counts, so address/data come from its first cycle.
  assign evt     = bus.mem_wen && !wen_q && (bus.mem_addr == TEST_PORT);
  assign push    = evt && (state == ST_CAPTURE);

  assign capturing = (state == ST_CAPTURE);
  assign done      = (state == ST_DONE);

`ifdef SNIFF_TIMESTAMP_EN
  logic [STAMP_W-1:0] stamp_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) stamp_q <= '0;
    else      stamp_q <= stamp_q + 1'b1;
  end

  assign fifo_in       = {stamp_q, swapped};
  assign bus.out_stamp = fifo_head[FW-1:32];
`else
  assign fifo_in = swapped;
`endif
  assign bus.out_data = fifo_head[31:0];

  sniff_fifo #(.WIDTH(FW), .DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (fifo_in),
    .push_ok   (push_ok),
    .pop_req   (bus.out_ready),
    .valid     (bus.out_valid),
    .head      (fifo_head)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= ST_IDLE;
      wen_q     <= 1'b0;
      overflow  <= 1'b0;
      event_cnt <= '0;
    end else begin
      wen_q <= bus.mem_wen;

      case (state)
        ST_IDLE:    if (evt && swapped == BEGIN_SYM) state <= ST_CAPTURE;
        // END still terminates the run even if its push was dropped.
        ST_CAPTURE: if (evt && swapped == END_SYM)   state <= ST_DONE;
        ST_DONE:    state <= ST_DONE;
        default:    state <= ST_IDLE;
      endcase

      if (push_ok && event_cnt != {CNT_W{1'b1}}) event_cnt <= event_cnt + 1'b1;
      if (push && !push_ok)                      overflow  <= 1'b1;
    end
  end

endmodule

// File: tb/tb_test_port_write_sniffer.sv
// Bench for test_port_write_sniffer (DEPTH=4): vector table plus hand-written reset/overflow sequences.
// Expected stream words go into a scoreboard queue when stimulus is driven and are
// compared at the negedge when the DUT hands over a word (out_valid && out_ready).
module tb_test_port_write_sniffer;

  localparam int          DEPTH = 4;
  localparam int          CNT_W = 16;
  localparam logic [29:0] TP    = 30'h10;

  logic             clk = 1'b0;
  logic             rst;
  logic             capturing;
  logic             done;
  logic             overflow;
  logic [CNT_W-1:0] event_cnt;

  test_port_write_sniffer_if sif();

  test_port_write_sniffer #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (sif),
    .capturing (capturing),
    .done      (done),
    .overflow  (overflow),
    .event_cnt (event_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [29:0] addr;
    logic [31:0] word;
    int          cycles;
    bit          pushes;
    logic [31:0] exp;
    bit          exp_cap;
    bit          exp_done;
    int          exp_cnt;
  } vec_t;

  vec_t        vecs[12];
  logic [31:0] sb[$];
  int          n_cmp  = 0;
  int          n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  // One clock: sample/compare the stream at negedge, then return 1 time unit after posedge.
  task automatic tick();
    @(negedge clk);
    if (sif.out_valid && sif.out_ready) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL unexpected_pop: got %h, want no word", sif.out_data);
      end else begin
        check("pop_data", sif.out_data, sb.pop_front());
      end
    end
    @(posedge clk);
    #1;
  endtask

  // Store held for 'cycles' clocks; address/data are scrambled after the first cycle
  // so only the first-cycle values may reach the stream.
  task automatic write_evt(input logic [29:0] addr, input logic [31:0] word, input int cycles,
                           input bit pushes, input logic [31:0] exp);
    sif.mem_addr  = addr;
    sif.mem_wdata = word;
    sif.mem_wen   = 1'b1;
    if (pushes) sb.push_back(exp);
    tick();
    for (int i = 1; i < cycles; i++) begin
      sif.mem_addr  = addr ^ 30'h1;
      sif.mem_wdata = ~word;
      tick();
    end
    sif.mem_wen = 1'b0;
    tick();
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_out_valid"}, sif.out_valid, 0);
    check({tag, "_out_data"},  sif.out_data,  0);
    check({tag, "_capturing"}, capturing,     0);
    check({tag, "_done"},      done,          0);
    check({tag, "_overflow"},  overflow,      0);
    check({tag, "_event_cnt"}, event_cnt,     0);
  endtask

  task automatic apply_reset();
    sif.mem_wen = 1'b0;
    rst = 1'b0;
    sb.delete();
    tick();
  endtask

  initial begin
    rst           = 1'b0;
    sif.mem_addr  = '0;
    sif.mem_wdata = '0;
    sif.mem_wen   = 1'b0;
    sif.out_ready = 1'b1;

    //          addr   word          cyc push exp           cap done cnt
    vecs[0]  = '{TP,     32'h34120000, 1, 0, 32'h0,        0, 0, 0};
    vecs[1]  = '{TP,     32'hCDAB0000, 1, 0, 32'h0,        0, 0, 0};
    vecs[2]  = '{TP,     32'h5DFDFFFF, 2, 0, 32'h0,        0, 0, 0};
    vecs[3]  = '{TP,     32'h68010000, 1, 0, 32'h0,        1, 0, 0};
    vecs[4]  = '{30'h11, 32'h34120000, 1, 0, 32'h0,        1, 0, 0};
    vecs[5]  = '{30'h11, 32'h68010000, 3, 0, 32'h0,        1, 0, 0};
    vecs[6]  = '{TP,     32'h34120000, 1, 1, 32'h00001234, 1, 0, 1};
    vecs[7]  = '{TP,     32'hCDAB0000, 1, 1, 32'h0000ABCD, 1, 0, 2};
    vecs[8]  = '{TP,     32'h00001A09, 4, 1, 32'h091A0000, 1, 0, 3};
    vecs[9]  = '{TP,     32'h68010000, 1, 1, 32'h00000168, 1, 0, 4};
    vecs[10] = '{TP,     32'h5DFDFFFF, 1, 1, 32'hFFFFFD5D, 0, 1, 5};
    vecs[11] = '{TP,     32'h34120000, 1, 0, 32'h0,        0, 1, 5};

    // Reset state
    tick();
    tick();
    check_reset_vals("reset");
    rst = 1'b1;
    tick();

    // Table: pre-Begin, Begin, off-port writes, basic capture, stall collapse, End, post-End
    for (int i = 0; i < 12; i++) begin
      write_evt(vecs[i].addr, vecs[i].word, vecs[i].cycles, vecs[i].pushes, vecs[i].exp);
      check($sformatf("vec%0d_capturing", i), capturing, vecs[i].exp_cap);
      check($sformatf("vec%0d_done", i),      done,      vecs[i].exp_done);
      check($sformatf("vec%0d_event_cnt", i), event_cnt, vecs[i].exp_cnt);
    end
    repeat (4) tick();
    check("table_sb_drained", sb.size(), 0);
    check("table_out_valid",  sif.out_valid, 0);

    // Reset mid-CAPTURE with 3 queued entries, then re-Begin
    apply_reset();
    rst = 1'b1;
    tick();
    sif.out_ready = 1'b0;
    write_evt(TP, 32'h68010000, 1, 0, 32'h0);
    write_evt(TP, 32'h11000000, 1, 1, 32'h00000011);
    write_evt(TP, 32'h22000000, 1, 1, 32'h00000022);
    write_evt(TP, 32'h33000000, 1, 1, 32'h00000033);
    check("mid_event_cnt", event_cnt, 3);
    check("mid_out_valid", sif.out_valid, 1);
    apply_reset();
    check_reset_vals("midrst");
    rst = 1'b1;
    tick();
    sif.out_ready = 1'b1;
    write_evt(TP, 32'h34120000, 1, 0, 32'h0);
    check("restart_idle_cap", capturing, 0);
    write_evt(TP, 32'h68010000, 1, 0, 32'h0);
    write_evt(TP, 32'h34120000, 1, 1, 32'h00001234);
    repeat (3) tick();
    check("restart_capturing", capturing, 1);
    check("restart_event_cnt", event_cnt, 1);
    check("restart_sb_drained", sb.size(), 0);

    // Overflow: 5 events into 4 slots, then a push coincident with a pop at full
    apply_reset();
    rst = 1'b1;
    tick();
    sif.out_ready = 1'b0;
    write_evt(TP, 32'h68010000, 1, 0, 32'h0);
    for (int i = 1; i <= 4; i++)
      write_evt(TP, 32'(i) | 32'hA0, 1, 1, (32'(i) | 32'hA0) << 24);
    write_evt(TP, 32'h000000A5, 1, 0, 32'h0);
    check("ovf_flag",      overflow,      1);
    check("ovf_event_cnt", event_cnt,     4);
    check("ovf_out_valid", sif.out_valid, 1);
    check("ovf_head",      sif.out_data,  32'hA1000000);
    sif.mem_addr  = TP;
    sif.mem_wdata = 32'h000000A6;
    sif.mem_wen   = 1'b1;
    sif.out_ready = 1'b1;
    sb.push_back(32'hA6000000);
    tick();
    sif.mem_wen = 1'b0;
    repeat (6) tick();
    check("ovf_push_pop_cnt", event_cnt,     5);
    check("ovf_drain_valid",  sif.out_valid, 0);
    check("ovf_hold_data",    sif.out_data,  32'hA6000000);
    check("ovf_sticky",       overflow,      1);
    check("ovf_sb_drained",   sb.size(),     0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
